// File: rtl/button8_in_pkg.sv
// Shared address map for the memory-mapped I/O peripherals on the CPU data bus,
// and the constants used by the button8_in reader.
package button8_in_pkg;

  localparam logic [31:0] LED8_DATA_ADDR = 32'h0000_03fc;
  localparam logic [31:0] LED8_STAT_ADDR = 32'h0000_03f8;
  localparam logic [31:0] BTN8_DATA_ADDR = 32'h0000_03f4;
  localparam logic [31:0] BTN8_STAT_ADDR = 32'h0000_03f0;

  // Position of the any-pending summary bit in the status word.
  localparam int unsigned STAT_ANY_BIT = 8;

  typedef enum logic [1:0] {
    SEL_NONE,
    SEL_DATA,
    SEL_STAT
  } rd_sel_e;

endpackage

// File: rtl/button8_in_debounce_bit.sv
// One input pin: two-flop synchronizer, stability counter and debounced level.
// rise is high during the cycle whose closing edge takes stable from 0 to 1.
module debounce_bit #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned CNT_W           = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic pin,
  output logic stable,
  output logic rise
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      stable <= 1'b0;
      cnt    <= '0;
    end else begin
      sync1 <= pin;
      sync2 <= sync1;
      if (sync2 == stable) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        stable <= sync2;
        cnt    <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  assign rise = sync2 & ~stable & (cnt == LAST);

endmodule

// File: rtl/button8_in.sv
// Eight debounced button/switch inputs with sticky rising-edge flags,
// readable combinationally at two data-bus addresses.
module button8_in
  import button8_in_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned CNT_W           = 16,
  parameter logic [31:0] DATA_ADDR       = BTN8_DATA_ADDR,
  parameter logic [31:0] STAT_ADDR       = BTN8_STAT_ADDR
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  pin_in,
  input  logic [31:0] rw_addr,
  input  logic [31:0] w_data,
  input  logic        w_en,
  output logic [31:0] r_data,
  output logic        r_hit
);

  logic [7:0] stable;
  logic [7:0] rise;
  logic [7:0] pending;
  logic [7:0] clr_mask;
  rd_sel_e    sel;
  logic       unused_wdata;

  for (genvar i = 0; i < 8; i++) begin : g_bit
    debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_db (
      .clock (clock),
      .reset (reset),
      .pin   (pin_in[i]),
      .stable(stable[i]),
      .rise  (rise[i])
    );
  end

  assign clr_mask     = (w_en && rw_addr == STAT_ADDR) ? w_data[7:0] : '0;
  assign unused_wdata = ^w_data[31:8];

  // Set is applied after the clear so a same-edge rise keeps its flag.
  always_ff @(posedge clock) begin
    if (reset) begin
      pending <= '0;
    end else begin
      pending <= (pending & ~clr_mask) | rise;
    end
  end

  always_comb begin
    sel = SEL_NONE;
    if (rw_addr == DATA_ADDR) begin
      sel = SEL_DATA;
    end else if (rw_addr == STAT_ADDR) begin
      sel = SEL_STAT;
    end
  end

  assign r_hit = (sel != SEL_NONE);

  always_comb begin
    r_data = '0;
    case (sel)
      SEL_DATA: r_data[7:0] = stable;
      SEL_STAT: begin
        r_data[7:0]          = pending;
        r_data[STAT_ANY_BIT] = |pending;
      end
      default: r_data = '0;
    endcase
  end

endmodule

// File: tb/tb_button8_in.sv
// Scoreboard bench for button8_in with a short debounce window.
module tb_button8_in;

  localparam logic [31:0] A_DATA = 32'h0000_03f4;
  localparam logic [31:0] A_STAT = 32'h0000_03f0;
  localparam logic [31:0] A_LED  = 32'h0000_03fc;

  logic        clock = 1'b0;
  logic        reset;
  logic [7:0]  pin_in;
  logic [31:0] rw_addr;
  logic [31:0] w_data;
  logic        w_en;
  logic [31:0] r_data;
  logic        r_hit;

  typedef struct {
    string       tag;
    logic [31:0] addr;
    logic [31:0] exp_data;
    logic        exp_hit;
  } rd_t;

  rd_t sb[$];
  int  n_cmp = 0;
  int  n_bad = 0;

  button8_in #(
    .DEBOUNCE_CYCLES(4),
    .CNT_W          (16)
  ) dut (
    .clock  (clock),
    .reset  (reset),
    .pin_in (pin_in),
    .rw_addr(rw_addr),
    .w_data (w_data),
    .w_en   (w_en),
    .r_data (r_data),
    .r_hit  (r_hit)
  );

  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic expect_rd(input string tag, input logic [31:0] addr,
                           input logic [31:0] exp_data, input logic exp_hit);
    rd_t e;
    e.tag = tag; e.addr = addr; e.exp_data = exp_data; e.exp_hit = exp_hit;
    sb.push_back(e);
  endtask

  // Reads are combinational, so each queued entry is resolved within the cycle.
  task automatic drain();
    rd_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      rw_addr = e.addr;
      #1;
      check({e.tag, ".data"}, r_data, e.exp_data);
      check({e.tag, ".hit"}, {31'b0, r_hit}, {31'b0, e.exp_hit});
    end
  endtask

  task automatic expect_both(input string tag, input logic [31:0] d, input logic [31:0] s);
    expect_rd({tag, ".d"}, A_DATA, d, 1'b1);
    expect_rd({tag, ".s"}, A_STAT, s, 1'b1);
    drain();
  endtask

  // Store held for one cycle; takes effect at the edge ending the cycle.
  task automatic store(input logic [31:0] addr, input logic [31:0] data);
    rw_addr = addr; w_data = data; w_en = 1'b1;
    step();
    w_en = 1'b0; w_data = '0;
  endtask

  initial begin
    reset = 1'b1; pin_in = 8'hff; rw_addr = '0; w_data = '0; w_en = 1'b0;

    steps(2);
    reset = 1'b0; pin_in = 8'h00;
    expect_rd("rst_data", A_DATA, 32'h0, 1'b1);
    expect_rd("rst_stat", A_STAT, 32'h0, 1'b1);
    expect_rd("rst_led",  A_LED,  32'h0, 1'b0);
    drain();
    steps(8);
    expect_both("idle", 32'h00, 32'h000);

    // Press: pin driven just after edge 0.
    pin_in = 8'h05;
    for (int e = 1; e <= 5; e++) begin
      step();
      expect_rd("press_wait", A_DATA, 32'h00, 1'b1);
      drain();
    end
    step();
    expect_both("press", 32'h05, 32'h105);

    // 3-cycle glitch on pin 7 must not register.
    pin_in = 8'h85;
    steps(3);
    pin_in = 8'h05;
    for (int c = 0; c < 4; c++) begin
      steps(5);
      expect_both("glitch", 32'h05, 32'h105);
    end

    // 4-cycle hold on pin 7 registers at edge 6.
    pin_in = 8'h85;
    steps(5);
    expect_both("hold_wait", 32'h05, 32'h105);
    step();
    expect_both("hold", 32'h85, 32'h185);
    store(A_STAT, 32'h80);
    expect_both("clr7", 32'h85, 32'h105);

    // Clear sequence and a store to the data address.
    store(A_STAT, 32'h01);
    expect_both("clr0", 32'h85, 32'h104);
    store(A_DATA, 32'hffff_ffff);
    expect_both("wr_data", 32'h85, 32'h104);
    store(A_LED, 32'hffff_ffff);
    expect_both("wr_other", 32'h85, 32'h104);
    store(A_STAT, 32'h04);
    expect_both("clr2", 32'h85, 32'h000);

    // Clear of bit 1 lands on the edge where stable[1] rises.
    pin_in = 8'h87;
    steps(5);
    expect_both("coll_wait", 32'h85, 32'h000);
    store(A_STAT, 32'h02);
    expect_both("collision", 32'h87, 32'h102);

    // Release: level falls, flags untouched.
    pin_in = 8'h00;
    steps(5);
    expect_both("rel_wait", 32'h87, 32'h102);
    step();
    expect_both("release", 32'h00, 32'h102);

    // Reset on edge 3 of a press discards the partial count.
    pin_in = 8'h03;
    steps(2);
    reset = 1'b1;
    step();
    reset = 1'b0;
    expect_both("mid_rst", 32'h00, 32'h000);
    steps(3);
    expect_both("mid_rst_e6", 32'h00, 32'h000);
    steps(2);
    expect_both("mid_rst_e8", 32'h00, 32'h000);
    step();
    expect_both("mid_rst_e9", 32'h03, 32'h103);

    if (sb.size() != 0) begin
      n_cmp++; n_bad++;
      $display("FAIL sb_leftover: got %0d entries, want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/button8_in.md
# button8_in

Memory-mapped 8-input button/switch reader on the CPU data bus, alongside the LED8 output peripheral. It synchronizes and debounces eight raw input pins, then exposes the debounced levels at a data address. Latched rising-edge flags sit at a status address; the CPU polls that address and clears the flags with a write-1-to-clear store. Read data is combinational, so the top level can mux it into the data-memory read path on `r_hit`, the same way LED8 status is muxed.

## Interface
- `DEBOUNCE_CYCLES`, 50000: consecutive stable cycles required to accept a pin change; must be at least 1.
- `CNT_W`, 16: debounce counter width; must hold `DEBOUNCE_CYCLES-1`.
- `DATA_ADDR`, 32'h0000_03f4: read returns the debounced levels.
- `STAT_ADDR`, 32'h0000_03f0: read returns the pending flags; write clears flags (write-1-to-clear).
- `clock`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `pin_in`  in  8  raw asynchronous pins.
- `rw_addr`  in  32  CPU data address.
- `w_data`  in  32  CPU store data (rs2).
- `w_en`  in  1  CPU store strobe.
- `r_data`  out  32  combinational read data.
- `r_hit`  out  1  high when `rw_addr` equals `DATA_ADDR` or `STAT_ADDR`.

## Operation
- **Reset** (on a clock edge with `reset`=1): clears synchronizer flops, `stable[7:0]`, all counters and `pending[7:0]`. Resulting outputs:
  - `r_data` is 0 for any address.
  - `r_hit` depends on `rw_addr` only.
- **Synchronizer:** two flops per bit. `sync2` is the synchronized pin.
- **Debounce, per bit, each edge:**
  - If `sync2 == stable`: counter <= 0.
  - Else if counter == `DEBOUNCE_CYCLES-1`: `stable` <= `sync2`, counter <= 0.
  - Else: counter <= counter+1.
  - Any glitch shorter than `DEBOUNCE_CYCLES` cycles restarts the count and never reaches `stable`.
- **Edge capture:**
  - `pending[i]` is set on the edge where `stable[i]` goes 0→1.
  - A 1→0 transition does not set it.
  - Flags are sticky until cleared.
- **Clear:** when `w_en` is high and `rw_addr == STAT_ADDR`, `pending <= pending & ~w_data[7:0]`.
  - If a clear and a set hit the same bit on the same edge, the set wins and the bit stays 1.
  - Other bits are unaffected by the set.
- **Writes** to `DATA_ADDR` or any other address have no effect.
- **Read mux:**
  - `DATA_ADDR` → {24'b0, `stable`}.
  - `STAT_ADDR` → {23'b0, |`pending`, `pending`}; bit 8 is the any-pending summary.
  - Any other address → 0.

## Timing
- Pin change settled before edge 0 appears in `stable`, and in `pending` if rising, after edge `DEBOUNCE_CYCLES`+2. With D=4, that is edge 6.
- `r_data` and `r_hit` are purely combinational from `rw_addr`, `stable` and `pending`, with zero latency. This fits the single-cycle CPU load path.
- A clear store takes effect at the edge ending the store cycle. A read in the following cycle sees cleared flags.
- Reset asserted mid-debounce discards the partial count. After reset deasserts, a pin still held high needs the full latency again, then sets `pending`.
- The counter never wraps: it is bounded by `DEBOUNCE_CYCLES-1`.

## Structure
- Shared package: `DATA_ADDR` and `STAT_ADDR` defaults, kept next to the LED8 addresses (0x3fc, 0x3f8) so the address map lives in one place.
- The package also holds the status bit index constant (`STAT_ANY_BIT` = 8).
- One sub-module, `debounce_bit`, instantiated 8 times. It contains the synchronizer, the counter and the `stable` flop, and outputs `stable` plus a one-cycle `rise` pulse.
- The top holds `pending`, the clear logic and the read mux.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4.
- **Reset:** hold `reset` 2 cycles with `pin_in`=0xFF.
  - Reads of 0x3f4 and 0x3f0 return 0 immediately after.
  - `r_hit`=1 at both addresses and 0 at 0x3fc.
- **Press:** `pin_in` 0x00→0x05 held before edge 0.
  - Reading 0x3f4 returns 0x00 through edge 5 and 0x05 after edge 6.
  - Reading 0x3f0 returns 0x105 after edge 6.
- **Glitch:** `pin_in[7]` high for 3 cycles, then low.
  - 0x3f4 and 0x3f0 are unchanged for 20 cycles.
  - A 4-cycle+ hold on the same pin does register.
- **Clear:** from status 0x105, store 0x01 to 0x3f0 → status reads 0x104.
  - Store 0x04 → status reads 0x000.
  - Store to 0x3f4 → no change.
- **Collision:** schedule the clear store of bit 1 on the exact edge `stable[1]` rises → status bit 1 = 1 afterwards.
- **Release and mid-debounce reset:**
  - Release 0x05→0x00 → data reads 0x00 at edge 6; `pending` unchanged.
  - Pulse `reset` at edge 3 of a press → no update at edge 6; update occurs 6 edges after reset deasserts.
